score_checker: RTL and testbench
================================

// Module: score_checker
// PURPOSE
//  Consumer of the end-of-game score handshake (checkscore pulse + PlayerScore) from the gameplay controller.
//  Latches the finished game's score and the logged-in player's ID from authentication.
//  Compares the score against that player's personal best and the system-wide high score, updates both tables
//  and pulses record flags. Holds the result on a display bus for a fixed window, then returns to idle.
// PARAMETERS
//  NUM_PLAYERS  4    number of personal-best entries; IDs 0..NUM_PLAYERS-1 are valid
//  ID_W         2    width of player_id / high_id
//  SCORE_W      7    score width; must match the controller's PlayerScore
//  SHOW_CYCLES  16   cycles disp_valid stays high after an update (>=1)
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset, synchronous, active-low
//  checkscore   in   1        one-cycle pulse: game over, PlayerScore is final
//  PlayerScore  in   SCORE_W  final score of the game just ended
//  player_id    in   ID_W     ID of the logged-in player
//  busy         out  1        high from capture until SHOW ends; new checkscore ignored while high
//  best_score   out  SCORE_W  personal best of current player_id (combinational table read)
//  high_score   out  SCORE_W  system-wide high score (registered)
//  high_id      out  ID_W     ID holding high_score (registered)
//  new_personal out  1        one-cycle pulse: latched score beat the player's best
//  new_global   out  1        one-cycle pulse: latched score beat high_score
//  disp_score   out  SCORE_W  latched score, for display
//  disp_valid   out  1        high while disp_score is being shown
// BEHAVIOUR
//  Reset (rst=0 at an edge): state=IDLE; busy, new_personal, new_global, disp_valid = 0.
//   disp_score, high_score, high_id and every best[] entry = 0.
//   Reset mid-operation aborts the update; tables are cleared and no partial write occurs.
//  States: IDLE -> COMPARE -> UPDATE -> SHOW -> IDLE.
//  IDLE: on an edge sampling checkscore=1, latch s<=PlayerScore and id<=player_id; busy<=1; go to COMPARE.
//  COMPARE (1 cycle): pb<=(id<NUM_PLAYERS)&&(s>best[id]); hs<=(s>high_score). Strict '>': ties never update.
//   go to UPDATE.
//  UPDATE (1 cycle): if pb, best[id]<=s. If hs, high_score<=s and high_id<=id.
//   new_personal<=pb; new_global<=hs; disp_score<=s; disp_valid<=1; cnt<=0; go to SHOW.
//  SHOW: new_personal/new_global<=0, so each pulse lasts exactly 1 cycle. cnt increments each cycle.
//   When cnt==SHOW_CYCLES-1: disp_valid<=0, busy<=0, go to IDLE.
//  Latency: checkscore sampled at edge E0 -> tables and pulses visible after edge E0+2.
//   disp_valid high for SHOW_CYCLES cycles. busy falls after edge E0+2+SHOW_CYCLES.
//  checkscore while busy: ignored; no queueing. checkscore in IDLE is accepted even if held >1 cycle.
//  Both pulses may assert together. A score of 0 never sets a record.
//  Out-of-range id: personal table is untouched and new_personal=0; the global compare still applies.
//  PlayerScore and player_id are sampled only at capture; later changes do not affect the update.
//  Illegal state encoding -> IDLE on the next edge.
//  No arithmetic overflow: cnt is wide enough for SHOW_CYCLES-1; scores are only compared, never summed.
// TESTING
//  1 Reset, then checkscore with score=5, id=1 -> after E0+2: best[1]=5, high=5/id1; both pulses 1 cycle;
//    disp_score=5; disp_valid for 16 cycles.
//  2 Then score=3, id=2 -> best[2]=3, new_personal=1, new_global=0, high stays 5/id1.
//  3 Then score=5, id=2 -> best[2]=5, new_personal=1, new_global=0 (tie), high_id stays 1.
//  4 Then score=4, id=1 -> no pulses, tables unchanged, disp_score=4 shown for 16 cycles.
//  5 checkscore re-pulsed at E0+1 and at E0+5 with score=99 -> ignored; tables reflect only the first score.
//  6 rst=0 during SHOW after score=127 -> all outputs and tables 0, IDLE; next checkscore is accepted normally.

Source files
------------

// File: rtl/score_checker_if.sv
// End-of-game score handshake from the gameplay controller plus the record/display
// bus returned by score_checker.
interface score_checker_if #(
    parameter int unsigned ID_W    = 2,
    parameter int unsigned SCORE_W = 7
);
    logic               checkscore;
    logic [SCORE_W-1:0] PlayerScore;
    logic [ID_W-1:0]    player_id;
    logic               busy;
    logic [SCORE_W-1:0] best_score;
    logic [SCORE_W-1:0] high_score;
    logic [ID_W-1:0]    high_id;
    logic               new_personal;
    logic               new_global;
    logic [SCORE_W-1:0] disp_score;
    logic               disp_valid;

    modport master (
        output checkscore, PlayerScore, player_id,
        input  busy, best_score, high_score, high_id,
        input  new_personal, new_global, disp_score, disp_valid
    );

    modport slave (
        input  checkscore, PlayerScore, player_id,
        output busy, best_score, high_score, high_id,
        output new_personal, new_global, disp_score, disp_valid
    );
endinterface

// File: rtl/score_checker.sv
// Latches a finished game's score, updates the per-player best and global high score
// tables, pulses record flags and holds the result on the display bus for a fixed window.
module score_checker #(
    parameter int unsigned NUM_PLAYERS = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned SCORE_W     = 7,
    parameter int unsigned SHOW_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    score_checker_if.slave  bus
);
    localparam int unsigned CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, UPDATE, SHOW} state_t;

    state_t             r_state;
    logic [SCORE_W-1:0] r_s;
    logic [ID_W-1:0]    r_id;
    logic               r_pb;
    logic               r_hs;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [SCORE_W-1:0] r_high_score;
    logic [ID_W-1:0]    r_high_id;
    logic               r_new_personal;
    logic               r_new_global;
    logic [SCORE_W-1:0] r_disp_score;
    logic               r_disp_valid;
    logic [SCORE_W-1:0] r_best [NUM_PLAYERS];

    logic               w_id_ok;
    logic [SCORE_W-1:0] w_best_cur;
    logic               w_rd_ok;

    // Out-of-range IDs read as 0 and can never win the personal compare
    always_comb begin
        w_id_ok    = 32'(r_id) < NUM_PLAYERS;
        w_best_cur = w_id_ok ? r_best[r_id] : '0;
        w_rd_ok    = 32'(bus.player_id) < NUM_PLAYERS;
        bus.best_score = w_rd_ok ? r_best[bus.player_id] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_s            <= '0;
            r_id           <= '0;
            r_pb           <= 1'b0;
            r_hs           <= 1'b0;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_high_score   <= '0;
            r_high_id      <= '0;
            r_new_personal <= 1'b0;
            r_new_global   <= 1'b0;
            r_disp_score   <= '0;
            r_disp_valid   <= 1'b0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) r_best[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.checkscore) begin
                        r_s     <= bus.PlayerScore;
                        r_id    <= bus.player_id;
                        r_busy  <= 1'b1;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    r_pb    <= w_id_ok && (r_s > w_best_cur);
                    r_hs    <= r_s > r_high_score;
                    r_state <= UPDATE;
                end
                UPDATE: begin
                    if (r_pb) r_best[r_id] <= r_s;
                    if (r_hs) begin
                        r_high_score <= r_s;
                        r_high_id    <= r_id;
                    end
                    r_new_personal <= r_pb;
                    r_new_global   <= r_hs;
                    r_disp_score   <= r_s;
                    r_disp_valid   <= 1'b1;
                    r_cnt          <= '0;
                    r_state        <= SHOW;
                end
                SHOW: begin
                    r_new_personal <= 1'b0;
                    r_new_global   <= 1'b0;
                    r_cnt          <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(SHOW_CYCLES - 1)) begin
                        r_disp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.high_score   = r_high_score;
    assign bus.high_id      = r_high_id;
    assign bus.new_personal = r_new_personal;
    assign bus.new_global   = r_new_global;
    assign bus.disp_score   = r_disp_score;
    assign bus.disp_valid   = r_disp_valid;
endmodule

// File: tb/tb_score_checker.sv
// Directed bench for score_checker: record detection, tie/zero handling, busy lockout
// and mid-display reset, with hand-computed table contents after each game.
module tb_score_checker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    score_checker_if #(.ID_W(2), .SCORE_W(7)) bus ();

    score_checker #(
        .NUM_PLAYERS(4),
        .ID_W(2),
        .SCORE_W(7),
        .SHOW_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Walks player_id over every table entry and compares against the expected contents.
    task automatic check_tables(input string tag, input int b0, input int b1, input int b2,
                                input int b3, input int hs, input int hid);
        int exp_b [4];
        exp_b = '{b0, b1, b2, b3};
        for (int i = 0; i < 4; i++) begin
            bus.player_id = 2'(i);
            #1;
            check($sformatf("%s_best%0d", tag, i), int'(bus.best_score), exp_b[i]);
        end
        check({tag, "_high"}, int'(bus.high_score), hs);
        check({tag, "_high_id"}, int'(bus.high_id), hid);
    endtask

    // Runs one game from capture through the end of the display window.
    task automatic game(input string tag, input int sc, input int id, input bit epb,
                        input bit ehs, input bit repulse);
        int  hi;
        int  fall_n;
        hi     = 0;
        fall_n = -1;
        @(negedge clk);
        bus.checkscore  = 1'b1;
        bus.PlayerScore = 7'(sc);
        bus.player_id   = 2'(id);
        @(negedge clk);
        // Inputs change after capture; the update must use the latched values.
        bus.PlayerScore = 7'd99;
        bus.player_id   = ~2'(id);
        check({tag, "_busy_rise"}, int'(bus.busy), 1);
        for (int n = 0; n < 40; n++) begin
            bus.checkscore = repulse && (n == 0 || n == 4);
            if (n == 1) begin
                check({tag, "_pers_early"}, int'(bus.new_personal), 0);
                check({tag, "_valid_early"}, int'(bus.disp_valid), 0);
            end
            if (n == 2) begin
                check({tag, "_new_personal"}, int'(bus.new_personal), int'(epb));
                check({tag, "_new_global"}, int'(bus.new_global), int'(ehs));
                check({tag, "_disp_score"}, int'(bus.disp_score), sc);
            end
            if (n == 3) begin
                check({tag, "_pers_pulse_end"}, int'(bus.new_personal), 0);
                check({tag, "_glob_pulse_end"}, int'(bus.new_global), 0);
            end
            if (bus.disp_valid) hi++;
            if (!bus.busy) begin
                fall_n = n;
                break;
            end
            @(negedge clk);
        end
        bus.checkscore = 1'b0;
        check({tag, "_busy_fall_edge"}, fall_n, 18);
        check({tag, "_valid_cycles"}, hi, 16);
    endtask

    initial begin
        bus.checkscore  = 1'b0;
        bus.PlayerScore = '0;
        bus.player_id   = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.disp_valid), 0);
        check("rst_disp", int'(bus.disp_score), 0);
        check_tables("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        game("t1", 5, 1, 1'b1, 1'b1, 1'b0);
        check_tables("t1", 0, 5, 0, 0, 5, 1);
        game("t2", 3, 2, 1'b1, 1'b0, 1'b0);
        check_tables("t2", 0, 5, 3, 0, 5, 1);
        game("t3_tie", 5, 2, 1'b1, 1'b0, 1'b0);
        check_tables("t3", 0, 5, 5, 0, 5, 1);
        game("t4_none", 4, 1, 1'b0, 1'b0, 1'b0);
        check_tables("t4", 0, 5, 5, 0, 5, 1);
        game("t5_busy", 6, 3, 1'b1, 1'b1, 1'b1);
        check_tables("t5", 0, 5, 5, 6, 6, 3);
        game("t_zero", 0, 0, 1'b0, 1'b0, 1'b0);
        check_tables("tz", 0, 5, 5, 6, 6, 3);

        // Reset in the middle of the display window after a maximum score.
        @(negedge clk);
        bus.checkscore  = 1'b1;
        bus.PlayerScore = 7'd127;
        bus.player_id   = 2'd0;
        @(negedge clk);
        bus.checkscore = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_pre_valid", int'(bus.disp_valid), 1);
        check("t6_pre_high", int'(bus.high_score), 127);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t6_busy", int'(bus.busy), 0);
        check("t6_valid", int'(bus.disp_valid), 0);
        check("t6_disp", int'(bus.disp_score), 0);
        check("t6_pers", int'(bus.new_personal), 0);
        check("t6_glob", int'(bus.new_global), 0);
        check_tables("t6", 0, 0, 0, 0, 0, 0);
        game("t6_after", 2, 0, 1'b1, 1'b1, 1'b0);
        check_tables("t6a", 2, 0, 0, 0, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
